// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage load/store port: word-organised RAM behind a
// fixed-latency request/ready handshake, with byte/half/word lane steering and load extension.
module data_mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int DM_MEM_DEPTH = 4096,
    parameter int FUNC3_WIDTH  = 3,
    parameter int LATENCY      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [FUNC3_WIDTH-1:0] func3,
    input  logic [DATA_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   ready,
    output logic                   error,
    output logic [1:0]             dbgState
);

    // Handshake: the initiator raises mem_read/mem_write and holds it with stable
    // func3/addr/wdata until it sees ready=1; that cycle completes the access and a
    // request still present on the following cycle is a new access.

    localparam int AW = $clog2(DM_MEM_DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    localparam logic [FUNC3_WIDTH-1:0] F3_B  = 'b000;
    localparam logic [FUNC3_WIDTH-1:0] F3_H  = 'b001;
    localparam logic [FUNC3_WIDTH-1:0] F3_W  = 'b010;
    localparam logic [FUNC3_WIDTH-1:0] F3_BU = 'b100;
    localparam logic [FUNC3_WIDTH-1:0] F3_HU = 'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateE;

    stateE                  state;
    logic [CW-1:0]          count;
    logic                   capRd;
    logic                   capWr;
    logic [FUNC3_WIDTH-1:0] capF3;
    logic [AW+1:0]          capAddr;
    logic [DATA_WIDTH-1:0]  capWdata;

    logic [DATA_WIDTH-1:0]  mem [DM_MEM_DEPTH];

    logic                   req;
    logic                   accRd;
    logic                   accWr;
    logic [FUNC3_WIDTH-1:0] accF3;
    logic [AW+1:0]          accAddr;
    logic [DATA_WIDTH-1:0]  accWdata;
    logic [AW-1:0]          accIdx;
    logic [1:0]             lane;
    logic                   accErr;
    logic                   goDone;
    logic                   memWe;
    logic [3:0]             byteEn;
    logic [DATA_WIDTH-1:0]  wLanes;
    logic [DATA_WIDTH-1:0]  memWord;
    logic [7:0]             selByte;
    logic [15:0]            selHalf;
    logic [DATA_WIDTH-1:0]  loadVal;
    logic                   unusedAddrHi;

    assign req          = mem_read | mem_write;
    assign unusedAddrHi = ^addr[DATA_WIDTH-1:AW+2];

    // In IDLE the live inputs describe the access (needed when LATENCY==1);
    // afterwards only the captured copy is used.
    always_comb begin
        accRd    = capRd;
        accWr    = capWr;
        accF3    = capF3;
        accAddr  = capAddr;
        accWdata = capWdata;
        if (state == IDLE) begin
            accRd    = mem_read;
            accWr    = mem_write;
            accF3    = func3;
            accAddr  = addr[AW+1:0];
            accWdata = wdata;
        end
    end

    assign accIdx = accAddr[AW+1:2];
    assign lane   = accAddr[1:0];

    always_comb begin
        accErr = 1'b0;
        if (accRd && accWr) begin
            accErr = 1'b1;
        end else if (accWr) begin
            accErr = !(accF3 == F3_B || accF3 == F3_H || accF3 == F3_W);
        end else begin
            accErr = !(accF3 == F3_B || accF3 == F3_H || accF3 == F3_W ||
                       accF3 == F3_BU || accF3 == F3_HU);
        end
        if ((accF3 == F3_H || accF3 == F3_HU) && lane[0]) begin
            accErr = 1'b1;
        end
        if (accF3 == F3_W && lane != 2'b00) begin
            accErr = 1'b1;
        end
    end

    always_comb begin
        byteEn = 4'b0000;
        wLanes = accWdata;
        case (accF3)
            F3_B: begin
                byteEn[lane] = 1'b1;
                wLanes       = {4{accWdata[7:0]}};
            end
            F3_H: begin
                byteEn = lane[1] ? 4'b1100 : 4'b0011;
                wLanes = {2{accWdata[15:0]}};
            end
            F3_W:    byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    assign goDone = ((state == IDLE) && req && (LATENCY == 1)) ||
                    ((state == BUSY) && (count == LAST));
    assign memWe  = goDone && accWr && !accErr;

    assign memWord = mem[accIdx];
    assign selByte = memWord[{lane, 3'b000} +: 8];
    assign selHalf = lane[1] ? memWord[31:16] : memWord[15:0];

    always_comb begin
        loadVal = '0;
        case (accF3)
            F3_B:    loadVal = {{24{selByte[7]}}, selByte};
            F3_BU:   loadVal = {24'd0, selByte};
            F3_H:    loadVal = {{16{selHalf[15]}}, selHalf};
            F3_HU:   loadVal = {16'd0, selHalf};
            F3_W:    loadVal = memWord;
            default: loadVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[accIdx][8*i +: 8] <= wLanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rdata    <= '0;
            error    <= 1'b0;
            capRd    <= 1'b0;
            capWr    <= 1'b0;
            capF3    <= '0;
            capAddr  <= '0;
            capWdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        capRd    <= mem_read;
                        capWr    <= mem_write;
                        capF3    <= func3;
                        capAddr  <= addr[AW+1:0];
                        capWdata <= wdata;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            count <= CW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (count == LAST) begin
                        state <= DONE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdata <= '0;
                    error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // Result registers load on the edge entering DONE.
            if (goDone) begin
                error <= accErr;
                rdata <= (accRd && !accErr) ? loadVal : '0;
            end
        end
    end

    assign ready    = ((state == IDLE) && !req) || (state == DONE);
    assign dbgState = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: byte-level memory model, per-cycle handshake
// checker with an expected-result queue, and literal checks on selected loads.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        error;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [31:0] mdl [DEPTH];

  data_mem_responder #(
    .DATA_WIDTH(32), .DM_MEM_DEPTH(DEPTH), .FUNC3_WIDTH(3), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ready(ready), .error(error), .dbgState(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: memory as bytes within words, access size from func3.
  task automatic model_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic err, output logic [31:0] res);
    int size;
    int idx;
    int ofs;
    bit legal;
    logic [31:0] w;
    logic [31:0] v;
    res = '0;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (rd && wr) legal = 0;
    else if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if ((a % size) != 0) legal = 0;
    err = !legal;
    if (!legal) return;
    idx = int'((a / 4) % DEPTH);
    ofs = int'(a % 4);
    if (wr) begin
      w = mdl[idx];
      for (int k = 0; k < size; k++) w[8*(ofs+k) +: 8] = wd[8*k +: 8];
      mdl[idx] = w;
    end else begin
      v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(mdl[idx][8*(ofs+k) +: 8]) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      res = v;
    end
  endtask

  // Per-cycle compare: idle -> ready=1; accepted access -> ready low LAT cycles then one pulse.
  bit active = 0;
  int age = 0;
  always @(negedge clk) begin
    logic exp_ready;
    logic [32:0] e;
    if (rst) begin
      active = 0;
    end else begin
      if (!active) begin
        if (mem_read || mem_write) begin
          active = 1;
          age = 0;
          exp_ready = 1'b0;
        end else begin
          exp_ready = 1'b1;
        end
      end else begin
        age++;
        exp_ready = (age == LAT);
      end
      check("ready", {31'd0, ready}, {31'd0, exp_ready});
      if (active && age == LAT) begin
        active = 0;
        if (exp_q.size() == 0) begin
          check("queue_empty_at_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("error_at_pulse", {31'd0, error}, {31'd0, e[32]});
          check("rdata_at_pulse", rdata, e[31:0]);
        end
      end else begin
        check("error_idle", {31'd0, error}, 32'd0);
        check("rdata_idle", rdata, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] got, output logic got_err, output int lat);
    logic e;
    logic [31:0] r;
    bit seen;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    model_access(rd, wr, f3, a, wd, e, r);
    exp_q.push_back({e, r});
    lat = 0; seen = 0; got = '0; got_err = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1;
        break;
      end
      lat++;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
    got = rdata;
    got_err = error;
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  logic [31:0] got;
  logic        gerr;
  int          lat;

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_rdata", rdata, 32'd0);

    // 1: reset during BUSY aborts a store
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h1111_1111, got, gerr, lat);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b1; func3 = 3'b010; addr = 32'h10; wdata = 32'h5555_5555;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    mem_write = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, got, gerr, lat);
    check("lw_after_abort", got, 32'h1111_1111);

    // 2: word store/load, latency
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, got, gerr, lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_rdata_zero", got, 32'd0);
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got, gerr, lat);
    check("lw_deadbeef", got, 32'hDEAD_BEEF);

    // 3: byte store and byte loads
    do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, got, gerr, lat);
    do_access(1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_00AA, got, gerr, lat);
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got, gerr, lat);
    check("lw_after_sb", got, 32'h1122_AA44);
    do_access(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, got, gerr, lat);
    check("lb_0x21", got, 32'hFFFF_FFAA);
    do_access(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, got, gerr, lat);
    check("lbu_0x21", got, 32'h0000_00AA);

    // 4: half store and half loads
    do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_8001, got, gerr, lat);
    do_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, got, gerr, lat);
    check("lh_0x22", got, 32'hFFFF_8001);
    do_access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, got, gerr, lat);
    check("lhu_0x22", got, 32'h0000_8001);

    // 5: error cases
    do_access(1'b1, 1'b0, 3'b010, 32'h23, 32'h0, got, gerr, lat);
    check("lw_misaligned_err", {31'd0, gerr}, 32'd1);
    check("lw_misaligned_rdata", got, 32'd0);
    do_access(1'b0, 1'b1, 3'b001, 32'h23, 32'h0000_FFFF, got, gerr, lat);
    check("sh_misaligned_err", {31'd0, gerr}, 32'd1);
    do_access(1'b0, 1'b1, 3'b100, 32'h20, 32'h0000_0077, got, gerr, lat);
    check("store_bad_func3_err", {31'd0, gerr}, 32'd1);
    do_access(1'b1, 1'b1, 3'b010, 32'h20, 32'h0, got, gerr, lat);
    check("rd_wr_both_err", {31'd0, gerr}, 32'd1);
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, got, gerr, lat);
    check("ram_unchanged", got, 32'h8001_AA44);

    // 6: address wrap and back-to-back traffic
    do_access(1'b0, 1'b1, 3'b010, DEPTH*4 + 8, 32'hCAFE_F00D, got, gerr, lat);
    do_access(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, got, gerr, lat);
    check("wrap_lw_0x8", got, 32'hCAFE_F00D);
    check("wrap_lw_latency", 32'(lat), 32'd2);

    go_idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
